// File: rtl/el2_lsu_addrchk_sched_if.sv
// Request, address-check and M-stage signals of the LSU address-check scheduler.
// Pure wiring, no latency.
// The slave modport is the scheduler; the master modport is its environment.
interface el2_lsu_addrchk_sched_if #(
    parameter int TAG_W = 4
);
    logic             core_req_valid;
    logic             core_req_ready;
    logic [31:0]      core_addr;
    logic [1:0]       core_size;
    logic             core_store;
    logic [3:0]       core_rs1_region;
    logic [TAG_W-1:0] core_tag;

    logic             dma_req_valid;
    logic             dma_req_ready;
    logic [31:0]      dma_addr;
    logic [1:0]       dma_size;
    logic             dma_store;
    logic [TAG_W-1:0] dma_tag;

    logic [31:0]      chk_start_addr;
    logic [31:0]      chk_end_addr;
    logic             chk_valid;
    logic             chk_load;
    logic             chk_store;
    logic             chk_dma;
    logic             chk_by;
    logic             chk_half;
    logic             chk_word;
    logic [3:0]       chk_rs1_region;
    logic             chk_access_fault;
    logic             chk_misaligned_fault;
    logic [3:0]       chk_mscause;
    logic             chk_addr_in_dccm;
    logic             chk_addr_in_pic;
    logic             chk_addr_external;

    logic             m_valid;
    logic             m_ready;
    logic             m_src;
    logic [TAG_W-1:0] m_tag;
    logic [31:0]      m_addr;
    logic             m_store;
    logic             m_fault;
    logic             m_misaligned;
    logic [3:0]       m_mscause;
    logic             m_dccm;
    logic             m_pic;
    logic             m_ext;

    logic             fault_pending;
    logic             flush_clear;

    modport slave (
        input  core_req_valid, core_addr, core_size, core_store, core_rs1_region, core_tag,
        output core_req_ready,
        input  dma_req_valid, dma_addr, dma_size, dma_store, dma_tag,
        output dma_req_ready,
        output chk_start_addr, chk_end_addr, chk_valid, chk_load, chk_store, chk_dma,
               chk_by, chk_half, chk_word, chk_rs1_region,
        input  chk_access_fault, chk_misaligned_fault, chk_mscause,
               chk_addr_in_dccm, chk_addr_in_pic, chk_addr_external,
        output m_valid, m_src, m_tag, m_addr, m_store, m_fault, m_misaligned,
               m_mscause, m_dccm, m_pic, m_ext,
        input  m_ready,
        output fault_pending,
        input  flush_clear
    );

    modport master (
        output core_req_valid, core_addr, core_size, core_store, core_rs1_region, core_tag,
        input  core_req_ready,
        output dma_req_valid, dma_addr, dma_size, dma_store, dma_tag,
        input  dma_req_ready,
        input  chk_start_addr, chk_end_addr, chk_valid, chk_load, chk_store, chk_dma,
               chk_by, chk_half, chk_word, chk_rs1_region,
        output chk_access_fault, chk_misaligned_fault, chk_mscause,
               chk_addr_in_dccm, chk_addr_in_pic, chk_addr_external,
        input  m_valid, m_src, m_tag, m_addr, m_store, m_fault, m_misaligned,
               m_mscause, m_dccm, m_pic, m_ext,
        output m_ready,
        input  fault_pending,
        output flush_clear
    );
endinterface

// File: rtl/el2_lsu_addrchk_sched.sv
// Arbitrates core vs DMA onto the single address-check path and registers results into a one-entry M stage.
// Latency: check drive is combinational; acceptance to m_valid is 1 cycle, back-to-back at 1/cycle.
// Backpressure: a request is accepted only when M is empty or being consumed; a core fault blocks the core until flush.
module el2_lsu_addrchk_sched #(
    parameter int TAG_W         = 4,
    parameter int MAX_CORE_WAIT = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    el2_lsu_addrchk_sched_if.slave         bus
);
    typedef enum logic {RUN, HOLD} state_t;

    localparam logic [3:0] MAX_W = 4'(MAX_CORE_WAIT);

    state_t           state_q, state_d;
    logic [3:0]       wait_cnt;
    logic             free;
    logic             core_elig;
    logic             core_win;
    logic             dma_win;
    logic             chk_fault;
    logic [31:0]      sel_addr;
    logic [1:0]       sel_size;
    logic             sel_store;
    logic [TAG_W-1:0] sel_tag;
    logic [3:0]       sel_region;
    logic [31:0]      sel_offset;

    // Arbitration: DMA by default, core once it has waited MAX_CORE_WAIT cycles or DMA is idle.
    always_comb begin
        free               = ~bus.m_valid | bus.m_ready;
        core_elig          = bus.core_req_valid & ~bus.fault_pending;
        core_win           = core_elig & (~bus.dma_req_valid | (wait_cnt == MAX_W));
        dma_win            = bus.dma_req_valid & ~core_win;
        bus.core_req_ready = core_win & free;
        bus.dma_req_ready  = dma_win & free;
        chk_fault          = bus.chk_access_fault | bus.chk_misaligned_fault;
    end

    // Select the winning request and build the address-check packet; all zero when idle.
    always_comb begin
        sel_addr   = '0;
        sel_size   = '0;
        sel_store  = 1'b0;
        sel_tag    = '0;
        sel_region = '0;
        if (core_win) begin
            sel_addr   = bus.core_addr;
            sel_size   = bus.core_size;
            sel_store  = bus.core_store;
            sel_tag    = bus.core_tag;
            sel_region = bus.core_rs1_region;
        end else if (dma_win) begin
            sel_addr   = bus.dma_addr;
            sel_size   = bus.dma_size;
            sel_store  = bus.dma_store;
            sel_tag    = bus.dma_tag;
            sel_region = bus.dma_addr[31:28];
        end
        // Size 3 is handled as a word access.
        case (sel_size)
            2'd0:    sel_offset = 32'd0;
            2'd1:    sel_offset = 32'd1;
            default: sel_offset = 32'd3;
        endcase
        bus.chk_valid      = core_win | dma_win;
        bus.chk_start_addr = sel_addr;
        bus.chk_end_addr   = bus.chk_valid ? (sel_addr + sel_offset) : 32'd0;
        bus.chk_load       = bus.chk_valid & ~sel_store;
        bus.chk_store      = bus.chk_valid & sel_store;
        bus.chk_dma        = dma_win;
        bus.chk_by         = bus.chk_valid & (sel_size == 2'd0);
        bus.chk_half       = bus.chk_valid & (sel_size == 2'd1);
        bus.chk_word       = bus.chk_valid & sel_size[1];
        bus.chk_rs1_region = sel_region;
    end

    // Count consecutive cycles the eligible core loses to DMA; frozen while M is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (bus.fault_pending || !bus.core_req_valid) begin
            wait_cnt <= '0;
        end else if (free) begin
            if (core_win) begin
                wait_cnt <= '0;
            end else if (dma_win && (wait_cnt != MAX_W)) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
        end
    end

    // M-stage holding register: load on acceptance, drop valid on a consume without refill.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.m_valid      <= 1'b0;
            bus.m_src        <= 1'b0;
            bus.m_tag        <= '0;
            bus.m_addr       <= '0;
            bus.m_store      <= 1'b0;
            bus.m_fault      <= 1'b0;
            bus.m_misaligned <= 1'b0;
            bus.m_mscause    <= '0;
            bus.m_dccm       <= 1'b0;
            bus.m_pic        <= 1'b0;
            bus.m_ext        <= 1'b0;
        end else if (bus.core_req_ready || bus.dma_req_ready) begin
            bus.m_valid      <= 1'b1;
            bus.m_src        <= dma_win;
            bus.m_tag        <= sel_tag;
            bus.m_addr       <= sel_addr;
            bus.m_store      <= sel_store;
            bus.m_fault      <= chk_fault;
            bus.m_misaligned <= bus.chk_misaligned_fault;
            bus.m_mscause    <= bus.chk_mscause;
            bus.m_dccm       <= bus.chk_addr_in_dccm;
            bus.m_pic        <= bus.chk_addr_in_pic;
            bus.m_ext        <= bus.chk_addr_external;
        end else if (bus.m_ready) begin
            bus.m_valid      <= 1'b0;
        end
    end

    // Fault FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Fault FSM next state: a faulting core acceptance blocks the core until flush_clear.
    always_comb begin
        state_d           = state_q;
        bus.fault_pending = (state_q == HOLD);
        case (state_q)
            RUN:     if (bus.core_req_ready && chk_fault) state_d = HOLD;
            HOLD:    if (bus.flush_clear) state_d = RUN;
            default: state_d = RUN;
        endcase
    end
endmodule
